// File: rtl/kws_audio_ingress.sv
// kws_audio_ingress: pad strobe sync, channel capture/reduce, sample FIFO and frame issue FSM
module kws_audio_ingress #(
  parameter int SAMPLE_W   = 16,
  parameter int NUM_CH     = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int FRAME_LEN  = 256,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] pad_sample,
  input  logic                pad_valid,
  input  logic                arm,
  input  logic                mode,
  input  logic [CH_W-1:0]     ch_sel,
  input  logic                clr,
  output logic                frame_start,
  output logic [SAMPLE_W-1:0] out_sample,
  output logic                out_valid,
  output logic                out_last,
  input  logic                out_ready,
  input  logic                acc_done,
  output logic                busy,
  output logic                overflow,
  output logic [LVL_W-1:0]    fifo_level,
  output logic [7:0]          frame_cnt
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(FRAME_LEN);
  localparam int SUM_W = SAMPLE_W + CH_W;
  localparam int NSLOT = 2 ** CH_W;

  typedef enum logic [1:0] {IDLE, START, STREAM, WAIT_DONE} state_t;

  logic                sync1_q, sync2_q, prev_q;
  logic                rise;
  logic [CH_W-1:0]     ch_idx_q;
  logic                grp_q;
  logic [SAMPLE_W-1:0] slot_q [NSLOT];
  logic [SUM_W-1:0]    sum_d;
  logic [SAMPLE_W-1:0] red_d;
  logic [SAMPLE_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_q, rd_q;
  logic [LVL_W-1:0]    lvl_q;
  logic                ovf_q;
  logic                full, empty, pop, push_ok;
  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [7:0]          frame_cnt_q;

  assign rise = sync2_q & ~prev_q;

  // two-flop synchroniser for the async strobe plus a delay flop for rising-edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= pad_valid;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // capture interleaved samples into per-channel slots; flag a completed group for the FIFO write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_idx_q <= '0;
      grp_q    <= 1'b0;
      for (int i = 0; i < NSLOT; i++) slot_q[i] <= '0;
    end else if (clr) begin
      ch_idx_q <= '0;
      grp_q    <= 1'b0;
    end else begin
      grp_q <= rise && ch_idx_q == CH_W'(NUM_CH - 1);
      if (rise) begin
        slot_q[ch_idx_q] <= pad_sample;
        ch_idx_q         <= (ch_idx_q == CH_W'(NUM_CH - 1)) ? '0 : ch_idx_q + 1'b1;
      end
    end
  end

  // reduce the group: the mean is the top SAMPLE_W bits of the sign-extended sum (floor shift)
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NUM_CH; i++) sum_d = sum_d + {{CH_W{slot_q[i][SAMPLE_W-1]}}, slot_q[i]};
    red_d = (NUM_CH == 1) ? slot_q[0] : mode ? sum_d[SUM_W-1:CH_W] : slot_q[ch_sel];
  end

  assign full    = lvl_q == LVL_W'(FIFO_DEPTH);
  assign empty   = lvl_q == '0;
  assign pop     = out_valid & out_ready;
  assign push_ok = grp_q & (~full | pop);

  // FIFO storage, no reset needed since reads are gated by occupancy
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= red_d;
  end

  // FIFO pointers, occupancy and sticky overflow on a dropped write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
      ovf_q <= 1'b0;
    end else if (clr) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_q + AW'(push_ok);
      rd_q  <= rd_q + AW'(pop);
      lvl_q <= lvl_q + LVL_W'(push_ok) - LVL_W'(pop);
      ovf_q <= ovf_q | (grp_q & full & ~pop);
    end
  end

  // frame issue sequencer with in-frame sample counter and completed-frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      frame_cnt_q <= '0;
    end else if (clr) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE:   if (arm) state_q <= START;
        START: begin
          cnt_q   <= '0;
          state_q <= STREAM;
        end
        STREAM: if (pop) begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(FRAME_LEN - 1)) state_q <= WAIT_DONE;
        end
        default: if (acc_done) begin
          frame_cnt_q <= frame_cnt_q + 8'd1;
          state_q     <= arm ? START : IDLE;
        end
      endcase
    end
  end

  assign out_valid   = state_q == STREAM && !empty;
  assign out_sample  = out_valid ? mem_q[rd_q] : '0;
  assign out_last    = out_valid && cnt_q == CW'(FRAME_LEN - 1);
  assign frame_start = state_q == START;
  assign busy        = state_q != IDLE;
  assign overflow    = ovf_q;
  assign fifo_level  = lvl_q;
  assign frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_kws_audio_ingress.sv
// tb_kws_audio_ingress: directed and randomized checks of capture, reduce, FIFO and framing
module tb_kws_audio_ingress;
  localparam int DEPTH = 4;
  localparam int FL    = 4;
  logic        clk = 0, rst_n = 0, pad_valid = 0, arm = 0, mode = 0, ch_sel = 0;
  logic        clr = 0, out_ready = 0, acc_done = 0;
  logic [15:0] pad_sample = '0;
  logic        frame_start, out_valid, out_last, busy, overflow;
  logic [15:0] out_sample;
  logic [2:0]  fifo_level;
  logic [7:0]  frame_cnt;
  int          n_cmp = 0, n_err = 0, fs_cnt = 0, pops = 0, pos = 0, fc = 0, fsb = 0;
  bit          ovf_m = 0;
  logic [15:0] mq[$];

  always #5 clk = ~clk;

  kws_audio_ingress #(.SAMPLE_W(16), .NUM_CH(2), .FIFO_DEPTH(DEPTH), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n), .pad_sample(pad_sample), .pad_valid(pad_valid), .arm(arm),
    .mode(mode), .ch_sel(ch_sel), .clr(clr), .frame_start(frame_start), .out_sample(out_sample),
    .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready), .acc_done(acc_done),
    .busy(busy), .overflow(overflow), .fifo_level(fifo_level), .frame_cnt(frame_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] reduce(input int a, input int b);
    return mode ? 16'((a + b) >>> 1) : (ch_sel ? 16'(b) : 16'(a));
  endfunction

  function automatic int rnd();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  task automatic push_model(input logic [15:0] v);
    if (mq.size() >= DEPTH) ovf_m = 1;
    else mq.push_back(v);
  endtask

  task automatic tick();
    @(negedge clk);
    if (frame_start) begin
      fs_cnt++;
      pos = 0;
    end
    if (out_valid && out_ready) begin
      chk("pop_has_model_entry", 32'(mq.size() != 0), 1);
      if (mq.size() != 0) chk("out_sample", out_sample, mq.pop_front());
      chk("out_last", out_last, pos == FL - 1);
      pos++;
      pops++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic group(input int a, input int b, input bit pw);
    pad_sample = 16'(a);
    pad_valid  = 1;
    repeat (3) tick();
    pad_valid = 0;
    repeat (3) tick();
    pad_sample = 16'(b);
    pad_valid  = 1;
    repeat (3) tick();
    if (pw) out_ready = 1;
    pad_valid = 0;
    tick();
    if (pw) out_ready = 0;
    push_model(reduce(a, b));
    repeat (2) tick();
  endtask

  task automatic rand_group(input bit pw);
    mode   = 1'($urandom_range(1));
    ch_sel = 1'($urandom_range(1));
    group(rnd(), rnd(), pw);
  endtask

  task automatic wait_pops(input int n);
    for (int i = 0; i < 100 && pops < n; i++) tick();
    chk("pops_reached", pops, n);
  endtask

  task automatic done_pulse();
    acc_done = 1;
    tick();
    acc_done = 0;
  endtask

  task automatic do_clr();
    clr = 1;
    tick();
    clr = 0;
    mq.delete();
    ovf_m = 0;
    fc = 0;
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_frame_start", frame_start, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_sample", out_sample, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_fifo_level", fifo_level, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    rst_n = 1;
    tick();
    mode = 1;
    group(100, -50, 0);
    group(-3, 0, 0);
    chk("avg_first", mq[0], 25);
    chk("avg_floor", mq[1], 16'hfffe);
    chk("level_two", fifo_level, 2);
    chk("idle_no_valid", out_valid, 0);
    chk("idle_not_busy", busy, 0);
    repeat (4) rand_group(0);
    chk("level_full", fifo_level, mq.size());
    chk("overflow_set", overflow, ovf_m);
    arm = 1;
    out_ready = 1;
    wait_pops(4);
    tick();
    chk("one_frame_start", fs_cnt, 1);
    chk("wait_busy", busy, 1);
    chk("wait_no_valid", out_valid, 0);
    arm = 0;
    done_pulse();
    fc++;
    chk("frame_cnt_1", frame_cnt, fc);
    chk("idle_after_done", busy, 0);
    done_pulse();
    chk("done_ignored_idle", frame_cnt, fc);
    chk("overflow_sticky", overflow, 1);
    out_ready = 0;
    do_clr();
    chk("clr_level", fifo_level, 0);
    chk("clr_overflow", overflow, 0);
    chk("clr_frame_cnt", frame_cnt, 0);
    chk("clr_idle", busy, 0);
    mode = 0;
    ch_sel = 1;
    group(100, -50, 0);
    group(-3, 0, 0);
    chk("sel_first", mq[0], 16'hffce);
    chk("sel_second", mq[1], 0);
    arm = 1;
    out_ready = 1;
    pops = 0;
    wait_pops(2);
    arm = 0;
    rand_group(0);
    rand_group(0);
    chk("arm_drop_full_frame", pops, 4);
    chk("arm_drop_wait", busy, 1);
    done_pulse();
    fc++;
    chk("arm_drop_frame_cnt", frame_cnt, fc);
    chk("arm_drop_idle", busy, 0);
    repeat (20) tick();
    chk("arm_drop_no_restart", fs_cnt, 2);
    out_ready = 0;
    do_clr();
    arm = 1;
    repeat (3) tick();
    repeat (4) rand_group(0);
    chk("pp_level_full", fifo_level, 4);
    chk("pp_streaming", busy, 1);
    pops = 0;
    rand_group(1);
    chk("pp_popped", pops, 1);
    chk("pp_level_kept", fifo_level, mq.size());
    chk("pp_no_overflow", overflow, ovf_m);
    out_ready = 1;
    wait_pops(4);
    arm = 0;
    tick();
    done_pulse();
    fc++;
    chk("pp_leftover", fifo_level, mq.size());
    chk("pp_idle", busy, 0);
    out_ready = 0;
    do_clr();
    arm = 1;
    out_ready = 1;
    pops = 0;
    rand_group(0);
    rand_group(0);
    out_ready = 0;
    rand_group(0);
    chk("mid_stream_pops", pops, 2);
    chk("mid_stream_valid", out_valid, 1);
    rst_n = 0;
    arm = 0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_sample", out_sample, 0);
    chk("arst_busy", busy, 0);
    chk("arst_level", fifo_level, 0);
    chk("arst_frame_start", frame_start, 0);
    tick();
    rst_n = 1;
    mq.delete();
    ovf_m = 0;
    fc = 0;
    pos = 0;
    fsb = fs_cnt;
    out_ready = 1;
    repeat (10) tick();
    chk("arst_no_restart", fs_cnt, fsb);
    chk("arst_no_pops", pops, 2);
    arm = 1;
    pops = 0;
    for (int f = 0; f < 256; f++) begin
      repeat (4) rand_group(0);
      done_pulse();
      fc = (fc + 1) % 256;
      if (f == 254) chk("frame_cnt_255", frame_cnt, fc);
    end
    chk("wrap_frame_cnt", frame_cnt, fc);
    chk("wrap_pops", pops, 1024);
    chk("wrap_starts", fs_cnt, fsb + 256);
    chk("wrap_level", fifo_level, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
